// File: rtl/rx_ocp_pkg.sv
// Shared encodings, state type and beat-count helper for the receive-side OCP master.
package rx_ocp_pkg;

   localparam logic [2:0] OCP_IDLE = 3'b000;
   localparam logic [2:0] OCP_WR   = 3'b001;
   localparam logic [2:0] OCP_RD   = 3'b010;

   localparam logic [1:0] RESP_NULL = 2'b00;
   localparam logic [1:0] RESP_DVA  = 2'b01;
   localparam logic [1:0] RESP_ERR  = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      RD_CMD,
      RD_RESP,
      ABORT
   } state_e;

   // A TLP length of 0 encodes 1024 DW; odd DW counts round up to a whole beat.
   function automatic logic [9:0] beat_count(input logic [9:0] len);
      logic [10:0] len_dw;
      len_dw = (len == 10'd0) ? 11'd1024 : {1'b0, len};
      return 10'((len_dw + 11'd1) >> 1);
   endfunction

endpackage

// File: rtl/rx_ocp_master_watchdog.sv
// No-progress cycle counter; saturates at the limit and reports expiry.
module rx_ocp_watchdog (
   input  logic       rx_clk,
   input  logic       rx_reset,
   input  logic       wd_clr,
   input  logic       wd_en,
   input  logic [9:0] wd_limit,
   output logic       wd_expired
);

   logic [9:0] cnt_q;
   logic [9:0] cnt_d;

   assign wd_expired = (cnt_q == wd_limit);

   always_comb begin
      cnt_d = cnt_q;
      if (wd_clr)
         cnt_d = '0;
      else if (wd_en && !wd_expired)
         cnt_d = cnt_q + 10'd1;
   end

   always_ff @(posedge rx_clk) begin
      if (rx_reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/rx_ocp_master.sv
// Runs one decoded PCIe memory request as a single OCP burst and streams read data out.
//
// state   | meaning
// IDLE    | waiting for a command, cmd_ready high
// WR      | streaming write beats to the OCP slave
// RD_CMD  | read command presented, waiting for SCmdAccept
// RD_RESP | forwarding read responses to the completion stream
// ABORT   | watchdog fired on a read; one error completion beat pending
module rx_ocp_master
   import rx_ocp_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 64,
   parameter int TIMEOUT    = 1023
) (
   input  logic                  rx_clk,
   input  logic                  rx_reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [9:0]            cmd_len,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_last,
   output logic [2:0]            MCmd,
   output logic [ADDR_WIDTH-1:0] MAddr,
   output logic [DATA_WIDTH-1:0] MData,
   output logic [9:0]            MBurstLength,
   output logic                  MRespAccept,
   input  logic                  SCmdAccept,
   input  logic [1:0]            SResp,
   input  logic [DATA_WIDTH-1:0] SData,
   output logic                  cpl_valid,
   input  logic                  cpl_ready,
   output logic [DATA_WIDTH-1:0] cpl_data,
   output logic                  cpl_last,
   output logic                  cpl_err,
   output logic                  len_err
);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [9:0]            beats_q, beats_d;
   logic                  progress;
   logic                  wd_clr;
   logic                  timeout;

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      beats_d      = beats_q;
      progress     = 1'b0;
      cmd_ready    = 1'b0;
      wr_ready     = 1'b0;
      MCmd         = OCP_IDLE;
      MAddr        = '0;
      MData        = '0;
      MBurstLength = '0;
      MRespAccept  = 1'b0;
      cpl_valid    = 1'b0;
      cpl_data     = '0;
      cpl_last     = 1'b0;
      cpl_err      = 1'b0;
      len_err      = 1'b0;

      unique case (state_q)
         IDLE: begin
            cmd_ready = !rx_reset;
            if (cmd_valid && !rx_reset) begin
               addr_d   = cmd_addr & ~ADDR_WIDTH'(7);
               beats_d  = beat_count(cmd_len);
               state_d  = cmd_write ? WR : RD_CMD;
               progress = 1'b1;
            end
         end
         WR: begin
            MCmd     = wr_valid ? OCP_WR : OCP_IDLE;
            MAddr    = addr_q;
            MData    = wr_data;
            wr_ready = SCmdAccept && wr_valid;
            if (wr_ready) begin
               progress = 1'b1;
               addr_d   = addr_q + ADDR_WIDTH'(8);
               beats_d  = beats_q - 10'd1;
               if (beats_q == 10'd1) begin
                  state_d = IDLE;
                  len_err = !wr_last;
               end
            end else if (timeout) begin
               state_d = IDLE;
               len_err = 1'b1;
            end
         end
         RD_CMD: begin
            MCmd         = OCP_RD;
            MAddr        = addr_q;
            MBurstLength = beats_q;
            if (SCmdAccept)
               state_d = RD_RESP;
            else if (timeout)
               state_d = ABORT;
         end
         RD_RESP: begin
            MRespAccept = cpl_ready;
            cpl_valid   = (SResp != RESP_NULL);
            cpl_data    = SData;
            cpl_err     = (SResp == RESP_ERR);
            cpl_last    = cpl_valid && (beats_q == 10'd1);
            if (cpl_valid && cpl_ready) begin
               progress = 1'b1;
               beats_d  = beats_q - 10'd1;
               if (beats_q == 10'd1)
                  state_d = IDLE;
            end else if (timeout) begin
               state_d = ABORT;
            end
         end
         ABORT: begin
            cpl_valid = 1'b1;
            cpl_err   = 1'b1;
            cpl_last  = 1'b1;
            if (cpl_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      wd_clr = progress || (state_d != state_q);
   end

   always_ff @(posedge rx_clk) begin
      if (rx_reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         beats_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         beats_q <= beats_d;
      end
   end

   rx_ocp_watchdog u_watchdog (
      .rx_clk     (rx_clk),
      .rx_reset   (rx_reset),
      .wd_clr     (wd_clr),
      .wd_en      (state_q != IDLE),
      .wd_limit   (10'(TIMEOUT)),
      .wd_expired (timeout)
   );

endmodule

// File: tb/tb_rx_ocp_master.sv
// Directed checks of rx_ocp_master: table of simple bursts plus hand-built corner sequences.
module tb_rx_ocp_master;
   import rx_ocp_pkg::*;

   logic        rx_clk = 1'b0;
   logic        rx_reset;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [63:0] cmd_addr;
   logic [9:0]  cmd_len;
   logic        wr_valid, wr_ready, wr_last;
   logic [63:0] wr_data;
   logic [2:0]  MCmd;
   logic [63:0] MAddr, MData;
   logic [9:0]  MBurstLength;
   logic        MRespAccept, SCmdAccept;
   logic [1:0]  SResp;
   logic [63:0] SData;
   logic        cpl_valid, cpl_ready, cpl_last, cpl_err, len_err;
   logic [63:0] cpl_data;

   int n_checks = 0;
   int n_errors = 0;

   always #5 rx_clk = ~rx_clk;

   rx_ocp_master dut (
      .rx_clk(rx_clk), .rx_reset(rx_reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_last(wr_last),
      .MCmd(MCmd), .MAddr(MAddr), .MData(MData), .MBurstLength(MBurstLength),
      .MRespAccept(MRespAccept), .SCmdAccept(SCmdAccept), .SResp(SResp), .SData(SData),
      .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_data(cpl_data),
      .cpl_last(cpl_last), .cpl_err(cpl_err), .len_err(len_err)
   );

   typedef struct {
      logic        wr;
      logic [9:0]  len;
      logic [63:0] addr;
      logic [63:0] exp_base;
      int          exp_beats;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
      wr_valid = 0; wr_data = '0; wr_last = 0;
      SCmdAccept = 0; SResp = RESP_NULL; SData = '0; cpl_ready = 0;
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send_cmd(input logic wr, input logic [9:0] len, input logic [63:0] addr);
      cmd_valid = 1; cmd_write = wr; cmd_len = len; cmd_addr = addr;
      #1 chk("cmd_ready", cmd_ready, 1);
      @(negedge rx_clk);
      cmd_valid = 0;
   endtask

   task automatic run_vec(input vec_t v);
      send_cmd(v.wr, v.len, v.addr);
      if (v.wr) begin
         for (int b = 0; b < v.exp_beats; b++) begin
            wr_valid = 1; SCmdAccept = 1; wr_data = 64'hA5A5_0000_0000_0000 + 64'(b);
            wr_last = (b == v.exp_beats - 1);
            #1;
            chk("vec_wr_mcmd", MCmd, OCP_WR);
            chk("vec_wr_maddr", MAddr, v.exp_base + 64'(8 * b));
            chk("vec_wr_mdata", MData, 64'hA5A5_0000_0000_0000 + 64'(b));
            chk("vec_wr_len_err", len_err, 0);
            @(negedge rx_clk);
         end
      end else begin
         SCmdAccept = 1;
         #1;
         chk("vec_rd_mcmd", MCmd, OCP_RD);
         chk("vec_rd_blen", MBurstLength, 10'(v.exp_beats));
         chk("vec_rd_maddr", MAddr, v.exp_base);
         @(negedge rx_clk);
         SCmdAccept = 0;
         for (int b = 0; b < v.exp_beats; b++) begin
            SResp = RESP_DVA; SData = 64'hD000_0000_0000_0000 + 64'(b); cpl_ready = 1;
            #1;
            chk("vec_rd_valid", cpl_valid, 1);
            chk("vec_rd_data", cpl_data, 64'hD000_0000_0000_0000 + 64'(b));
            chk("vec_rd_last", cpl_last, (b == v.exp_beats - 1));
            @(negedge rx_clk);
         end
      end
      idle_inputs();
      #1 chk("vec_back_idle", cmd_ready, 1);
      @(negedge rx_clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int n_beats, bad_last, bad_data, rd_cycles;
      logic seen;

      vecs[0] = '{1'b1, 10'd4,  64'h1000, 64'h1000, 2};
      vecs[1] = '{1'b1, 10'd1,  64'h2004, 64'h2000, 1};
      vecs[2] = '{1'b0, 10'd7,  64'h3000, 64'h3000, 4};
      vecs[3] = '{1'b1, 10'd5,  64'h400F, 64'h4008, 3};
      vecs[4] = '{1'b0, 10'd1,  64'h5000, 64'h5000, 1};
      vecs[5] = '{1'b0, 10'd10, 64'h6003, 64'h6000, 5};

      idle_inputs();
      rx_reset = 1;
      @(negedge rx_clk); @(negedge rx_clk);
      #1;
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_mcmd", MCmd, OCP_IDLE);
      chk("rst_cpl_valid", cpl_valid, 0);
      chk("rst_len_err", len_err, 0);
      chk("rst_wr_ready", wr_ready, 0);
      @(negedge rx_clk);
      rx_reset = 0;
      @(negedge rx_clk);
      SResp = RESP_DVA;
      #1;
      chk("post_rst_cmd_ready", cmd_ready, 1);
      chk("idle_sresp_ignored", cpl_valid, 0);
      chk("idle_mresp_accept", MRespAccept, 0);
      SResp = RESP_NULL;
      @(negedge rx_clk);

      foreach (vecs[i]) run_vec(vecs[i]);

      // Write of 3 DW with the slave stalling the first beat for 3 cycles.
      send_cmd(1, 10'd3, 64'h7000);
      wr_valid = 1; wr_data = 64'h1111_2222_3333_4444; SCmdAccept = 0;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("stall_mdata", MData, 64'h1111_2222_3333_4444);
         chk("stall_mcmd", MCmd, OCP_WR);
         chk("stall_wr_ready", wr_ready, 0);
         chk("stall_maddr", MAddr, 64'h7000);
         @(negedge rx_clk);
      end
      SCmdAccept = 1;
      #1 chk("stall_b0_ready", wr_ready, 1);
      @(negedge rx_clk);
      wr_data = 64'h5555_6666_7777_8888; wr_last = 1;
      #1;
      chk("stall_b1_maddr", MAddr, 64'h7008);
      chk("stall_len_err", len_err, 0);
      @(negedge rx_clk);
      idle_inputs();
      #1 chk("stall_done_idle", cmd_ready, 1);
      @(negedge rx_clk);

      // Read of 1024 DW with cpl_ready toggling.
      send_cmd(0, 10'd0, 64'h8000);
      SCmdAccept = 1;
      #1 chk("rd512_blen", MBurstLength, 10'd512);
      @(negedge rx_clk);
      SCmdAccept = 0;
      n_beats = 0; bad_last = 0; bad_data = 0;
      for (int c = 0; c < 1200; c++) begin
         SResp = RESP_DVA; SData = 64'(n_beats); cpl_ready = c[0];
         #1;
         if (cmd_ready) break;
         if (cpl_valid && cpl_ready) begin
            n_beats++;
            if (cpl_last != (n_beats == 512)) bad_last++;
            if (cpl_data != 64'(n_beats - 1)) bad_data++;
         end
         @(negedge rx_clk);
      end
      chk("rd512_beats", 64'(n_beats), 512);
      chk("rd512_last_pos", 64'(bad_last), 0);
      chk("rd512_data", 64'(bad_data), 0);
      idle_inputs();
      @(negedge rx_clk);

      // Read of 4 beats with an error response on beat 2.
      send_cmd(0, 10'd8, 64'h9000);
      SCmdAccept = 1;
      @(negedge rx_clk);
      SCmdAccept = 0;
      for (int b = 0; b < 4; b++) begin
         SResp = (b == 1) ? RESP_ERR : RESP_DVA; SData = 64'(b + 100); cpl_ready = 1;
         #1;
         chk("err_valid", cpl_valid, 1);
         chk("err_flag", cpl_err, (b == 1));
         chk("err_last", cpl_last, (b == 3));
         @(negedge rx_clk);
      end
      idle_inputs();
      #1 chk("err_done_idle", cmd_ready, 1);
      @(negedge rx_clk);

      // Read whose command is never accepted: watchdog abort.
      send_cmd(0, 10'd4, 64'hA000);
      rd_cycles = 0; seen = 0;
      for (int c = 0; c < 1100; c++) begin
         #1;
         if (cpl_valid) begin
            seen = 1;
            break;
         end
         if (MCmd == OCP_RD) rd_cycles++;
         @(negedge rx_clk);
      end
      chk("abort_seen", seen, 1);
      chk("abort_latency", (rd_cycles >= 1023 && rd_cycles <= 1024), 1);
      chk("abort_err", cpl_err, 1);
      chk("abort_last", cpl_last, 1);
      chk("abort_mcmd", MCmd, OCP_IDLE);
      @(negedge rx_clk);
      #1 chk("abort_held", cpl_valid, 1);
      cpl_ready = 1;
      @(negedge rx_clk);
      cpl_ready = 0;
      #1 chk("abort_done_idle", cmd_ready, 1);
      @(negedge rx_clk);

      // Write of 8 DW with wr_last on beat 2: mismatch reported on the 4th beat.
      send_cmd(1, 10'd8, 64'hB000);
      for (int b = 0; b < 4; b++) begin
         wr_valid = 1; SCmdAccept = 1; wr_data = 64'(b); wr_last = (b == 1);
         #1;
         chk("mis_wr_ready", wr_ready, 1);
         chk("mis_len_err", len_err, (b == 3));
         @(negedge rx_clk);
      end
      wr_last = 0;
      #1;
      chk("mis_back_idle", cmd_ready, 1);
      chk("mis_surplus_ignored", wr_ready, 0);
      chk("mis_len_err_pulse", len_err, 0);
      idle_inputs();
      @(negedge rx_clk);

      // Reset in the middle of a write burst.
      send_cmd(1, 10'd8, 64'hC000);
      wr_valid = 1; SCmdAccept = 1; wr_data = 64'h77;
      @(negedge rx_clk);
      rx_reset = 1;
      @(negedge rx_clk);
      #1;
      chk("midrst_mcmd", MCmd, OCP_IDLE);
      chk("midrst_maddr", MAddr, 0);
      chk("midrst_mdata", MData, 0);
      chk("midrst_wr_ready", wr_ready, 0);
      chk("midrst_cmd_ready", cmd_ready, 0);
      chk("midrst_cpl_last", cpl_last, 0);
      idle_inputs();
      rx_reset = 0;
      @(negedge rx_clk);
      #1 chk("midrst_release", cmd_ready, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
